// File: rtl/foo_handshake_driver.sv
// Ready/valid transmitter: queues {in1,in2} commands in a small FIFO and presents them to the DUT.
// Latency: command accepted at edge E0 into an idle driver is presented after edge E1 (2 cycles).
// Backpressure: cmd_ready drops when the FIFO is full; the presented beat holds until handshake_ready.
module foo_handshake_driver #(
   parameter int WIDTH   = 5,
   parameter int DEPTH   = 4,   // power of two, >= 2
   parameter int TIMEOUT = 15   // 1..255
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_in1,
   input  logic [WIDTH-1:0] cmd_in2,
   output logic             handshake_valid,
   input  logic             handshake_ready,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic [15:0]      sent_count,
   output logic             stall_timeout,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   // FIFO storage and pointers (one extra wrap bit distinguishes full from empty)
   logic [2*WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]        r_wptr;
   logic [AW:0]        r_rptr;

   // Output stage
   logic               r_hs_valid;
   logic [WIDTH-1:0]   r_in1;
   logic [WIDTH-1:0]   r_in2;

   // Status
   logic [15:0]        r_sent_count;
   logic [7:0]         r_stall_cnt;
   logic               r_stall_timeout;

   logic               w_empty;
   logic               w_full;
   logic [AW:0]        w_count;
   logic               w_push;
   logic               w_fire;
   logic               w_load;
   logic               w_stall;
   logic [2*WIDTH-1:0] w_head;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_count = r_wptr - r_rptr;

   // Space freed by a same-cycle pop is not offered to the producer; keeps cmd_ready off the ready path.
   assign cmd_ready = ASYNCRESETN && !w_full;
   assign w_push    = cmd_valid && cmd_ready;

   assign w_fire  = r_hs_valid && handshake_ready;
   assign w_stall = r_hs_valid && !handshake_ready;
   // Only entries already in the FIFO at this edge can be loaded, so a push into an
   // empty FIFO during a fire costs one idle cycle.
   assign w_load  = (!r_hs_valid || w_fire) && !w_empty;
   assign w_head  = r_mem[r_rptr[AW-1:0]];

   // FIFO data write; contents need no reset because the pointers gate visibility
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= {cmd_in1, cmd_in2};
      end
   end

   // FIFO pointer update: push advances tail, load pops head
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_load) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   // Output register: load head when empty or firing, otherwise hold (data stays stable under stall)
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_hs_valid <= 1'b0;
         r_in1      <= '0;
         r_in2      <= '0;
      end else if (w_load) begin
         r_hs_valid <= 1'b1;
         r_in1      <= w_head[2*WIDTH-1:WIDTH];
         r_in2      <= w_head[WIDTH-1:0];
      end else if (w_fire) begin
         r_hs_valid <= 1'b0;
      end
   end

   // Completed-transfer counter, wraps naturally at 16 bits
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_sent_count <= '0;
      end else if (w_fire) begin
         r_sent_count <= r_sent_count + 16'd1;
      end
   end

   // Saturating stall counter; any non-stalled cycle (fire or idle) clears it
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         if (r_stall_cnt != 8'hFF) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
         end
      end else begin
         r_stall_cnt <= '0;
      end
   end

   // Sticky timeout flag, set on the edge the counter steps from TIMEOUT-1 to TIMEOUT
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         r_stall_timeout <= 1'b0;
      end else if (w_stall && (r_stall_cnt == TIMEOUT_M1)) begin
         r_stall_timeout <= 1'b1;
      end
   end

   assign handshake_valid = r_hs_valid;
   assign in1             = r_in1;
   assign in2             = r_in2;
   assign sent_count      = r_sent_count;
   assign stall_timeout   = r_stall_timeout;
   assign busy            = (w_count != '0) || r_hs_valid;

endmodule

// File: tb/tb_foo_handshake_driver.sv
// Directed bench for foo_handshake_driver: vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later, well clear of the rising edge.
// Each vector's expectations describe the state before the rising edge of its own cycle.
module tb_foo_handshake_driver;

   logic        CLK;
   logic        ASYNCRESETN;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_in1;
   logic [4:0]  cmd_in2;
   logic        handshake_valid;
   logic        handshake_ready;
   logic [4:0]  in1;
   logic [4:0]  in2;
   logic [15:0] sent_count;
   logic        stall_timeout;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   foo_handshake_driver #(.WIDTH(5), .DEPTH(4), .TIMEOUT(15)) dut (
      .CLK             (CLK),
      .ASYNCRESETN     (ASYNCRESETN),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_in1         (cmd_in1),
      .cmd_in2         (cmd_in2),
      .handshake_valid (handshake_valid),
      .handshake_ready (handshake_ready),
      .in1             (in1),
      .in2             (in2),
      .sent_count      (sent_count),
      .stall_timeout   (stall_timeout),
      .busy            (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic        v;
      logic [4:0]  a;
      logic [4:0]  b;
      logic        r;
      logic        crdy;
      logic        hv;
      logic [4:0]  o1;
      logic [4:0]  o2;
      logic        bsy;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(logic v, logic [4:0] a, logic [4:0] b, logic r,
                               logic crdy, logic hv, logic [4:0] o1, logic [4:0] o2,
                               logic bsy, logic [15:0] cnt);
      vec_t t;
      t.v = v; t.a = a; t.b = b; t.r = r;
      t.crdy = crdy; t.hv = hv; t.o1 = o1; t.o2 = o2; t.bsy = bsy; t.cnt = cnt;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reset asserted on a falling edge, held across one rising edge, released on the next falling edge
   task automatic do_reset();
      ASYNCRESETN     = 1'b0;
      cmd_valid       = 1'b0;
      handshake_ready = 1'b0;
      cmd_in1         = '0;
      cmd_in2         = '0;
      @(negedge CLK);
      ASYNCRESETN = 1'b1;
   endtask

   vec_t tbl [17];

   initial begin
      int pushed, got, first_c, total;
      bit started, found, done;

      // Basic transfer (rows 0-3), then fill/backpressure with ready low and drain (rows 4-16).
      // sent_count is cumulative: the basic transfer contributes 1 before the 5 drained beats.
      //            v     a      b      r     crdy  hv    o1     o2     busy  cnt
      tbl[0]  = mk(1'b1, 5'h1F, 5'h03, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 16'd0);
      tbl[1]  = mk(1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 16'd0);
      tbl[2]  = mk(1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b1, 5'h1F, 5'h03, 1'b1, 16'd0);
      tbl[3]  = mk(1'b0, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 16'd1);
      tbl[4]  = mk(1'b1, 5'd0,  5'd10, 1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 1'b0, 16'd1);
      tbl[5]  = mk(1'b1, 5'd1,  5'd11, 1'b0, 1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 16'd1);
      tbl[6]  = mk(1'b1, 5'd2,  5'd12, 1'b0, 1'b1, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[7]  = mk(1'b1, 5'd3,  5'd13, 1'b0, 1'b1, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[8]  = mk(1'b1, 5'd4,  5'd14, 1'b0, 1'b1, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[9]  = mk(1'b1, 5'd5,  5'd15, 1'b0, 1'b0, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[10] = mk(1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[11] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  5'd10, 1'b1, 16'd1);
      tbl[12] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd1,  5'd11, 1'b1, 16'd2);
      tbl[13] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd2,  5'd12, 1'b1, 16'd3);
      tbl[14] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd3,  5'd13, 1'b1, 16'd4);
      tbl[15] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd4,  5'd14, 1'b1, 16'd5);
      tbl[16] = mk(1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 16'd6);

      // Reset state
      ASYNCRESETN = 1'b0; cmd_valid = 1'b0; handshake_ready = 1'b0;
      cmd_in1 = '0; cmd_in2 = '0;
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_hv",        32'(handshake_valid), 32'd0);
      check("rst_in1",       32'(in1), 32'd0);
      check("rst_in2",       32'(in2), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_count",     32'(sent_count), 32'd0);
      check("rst_timeout",   32'(stall_timeout), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      ASYNCRESETN = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 17; i++) begin
         cmd_valid       = tbl[i].v;
         cmd_in1         = tbl[i].a;
         cmd_in2         = tbl[i].b;
         handshake_ready = tbl[i].r;
         #1;
         check($sformatf("vec%0d_cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].crdy));
         check($sformatf("vec%0d_hv", i),        32'(handshake_valid), 32'(tbl[i].hv));
         check($sformatf("vec%0d_busy", i),      32'(busy), 32'(tbl[i].bsy));
         check($sformatf("vec%0d_count", i),     32'(sent_count), 32'(tbl[i].cnt));
         check($sformatf("vec%0d_timeout", i),   32'(stall_timeout), 32'd0);
         if (tbl[i].hv) begin
            check($sformatf("vec%0d_in1", i), 32'(in1), 32'(tbl[i].o1));
            check($sformatf("vec%0d_in2", i), 32'(in2), 32'(tbl[i].o2));
         end
         @(negedge CLK);
      end

      // Streaming: 20 commands, ready held high; expect 2-cycle fill then one beat per cycle
      do_reset();
      handshake_ready = 1'b1;
      pushed = 0; got = 0; first_c = -1; started = 1'b0;
      for (int c = 0; c < 40 && got < 20; c++) begin
         cmd_valid = (pushed < 20);
         cmd_in1   = 5'(pushed);
         cmd_in2   = 5'(31 - pushed);
         #1;
         if (cmd_valid && cmd_ready) pushed++;
         if (handshake_valid) begin
            if (!started) first_c = c;
            started = 1'b1;
            check("stream_in1", 32'(in1), 32'(got));
            check("stream_in2", 32'(in2), 32'(31 - got));
            got++;
         end else if (started) begin
            check("stream_gap", 32'(handshake_valid), 32'd1);
         end
         @(negedge CLK);
      end
      cmd_valid = 1'b0;
      #1;
      check("stream_latency", 32'(first_c), 32'd2);
      check("stream_beats",   32'(got), 32'd20);
      check("stream_count",   32'(sent_count), 32'd20);
      @(negedge CLK);

      // Stall timeout: one command presented with ready low
      do_reset();
      cmd_valid = 1'b1; cmd_in1 = 5'd7; cmd_in2 = 5'd9;
      @(negedge CLK);
      cmd_valid = 1'b0;
      found = 1'b0;
      for (int w = 0; w < 5; w++) begin
         #1;
         if (handshake_valid) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      check("stall_presented", 32'(found), 32'd1);
      for (int k = 1; k <= 15; k++) begin
         @(negedge CLK);
         #1;
         check($sformatf("stall_timeout_k%0d", k), 32'(stall_timeout), 32'(k >= 15));
         check($sformatf("stall_hold_in1_k%0d", k), 32'(in1), 32'd7);
      end
      handshake_ready = 1'b1;
      @(negedge CLK);
      #1;
      handshake_ready = 1'b0;
      check("stall_fire_hv",      32'(handshake_valid), 32'd0);
      check("stall_fire_count",   32'(sent_count), 32'd1);
      check("stall_sticky",       32'(stall_timeout), 32'd1);
      @(negedge CLK);
      #1;
      check("stall_sticky_later", 32'(stall_timeout), 32'd1);
      @(negedge CLK);

      // Reset mid-operation: one presented, three queued, sent_count and timeout nonzero
      for (int j = 0; j < 4; j++) begin
         cmd_valid = 1'b1; cmd_in1 = 5'(20 + j); cmd_in2 = 5'(j);
         @(negedge CLK);
      end
      cmd_valid = 1'b0;
      #1;
      check("mid_pre_hv",   32'(handshake_valid), 32'd1);
      check("mid_pre_in1",  32'(in1), 32'd20);
      check("mid_pre_full", 32'(cmd_ready), 32'd1);
      #1;
      ASYNCRESETN = 1'b0;
      #1;
      check("mid_rst_hv",        32'(handshake_valid), 32'd0);
      check("mid_rst_busy",      32'(busy), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("mid_rst_count",     32'(sent_count), 32'd0);
      check("mid_rst_timeout",   32'(stall_timeout), 32'd0);
      #1;
      ASYNCRESETN     = 1'b1;
      handshake_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         #1;
         check("mid_post_hv",    32'(handshake_valid), 32'd0);
         check("mid_post_count", 32'(sent_count), 32'd0);
      end
      @(negedge CLK);

      // Counter wrap: continuous streaming until 65536 transfers have fired
      do_reset();
      handshake_ready = 1'b1;
      cmd_valid = 1'b1;
      total = 0; done = 1'b0;
      for (int c = 0; c < 70000 && !done; c++) begin
         #1;
         if (total == 65535) check("wrap_ffff", 32'(sent_count), 32'h0000FFFF);
         if (total == 65536) begin
            check("wrap_zero", 32'(sent_count), 32'd0);
            done = 1'b1;
         end
         if (handshake_valid) total++;
         cmd_in1 = cmd_in1 + 5'd1;
         @(negedge CLK);
      end
      if (!done) check("wrap_budget", 32'(total), 32'd65536);
      cmd_valid = 1'b0;
      handshake_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
